// File: rtl/div_result_bcd.sv
// div_result_bcd: captures the divider quotient and converts it to BCD with a sequential double-dabble engine.
// Optional one-entry pending buffer for pulses arriving while busy: define DIV_RESULT_PENDING_EN.
module div_result_bcd #(
    parameter int QW     = 9,
    parameter int DIGITS = 3
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                finish_i,
    input  logic [QW-1:0]       quotient_i,
    input  logic                ready_i,
    output logic                valid_o,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic                err_o,
    output logic                busy_o,
    output logic                overrun_o
);
    // state | meaning
    // IDLE  | waiting for a finish pulse
    // SHIFT | double-dabble iterations in progress
    // DONE  | result presented, waiting for ready_i
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(QW + 1);
    localparam logic [CW-1:0] LAST     = CW'(QW);
    localparam logic [QW-1:0] ERR_CODE = '1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_next;

    logic [QW-1:0] sreg;
    logic [BW-1:0] acc;
    logic [BW-1:0] acc_adj;
    logic [BW-1:0] bcd_q;
    logic [CW-1:0] count;
    logic          err_q;
    logic          overrun_q;
    logic          handshake;
    logic          start;
    logic          start_err;
    logic [QW-1:0] start_q;
    logic          pend_valid;
    logic [QW-1:0] pend_q;
    logic          drop;

    assign handshake = (state == DONE) && ready_i;
    // A new conversion starts from the input in IDLE, or from the buffer on a DONE handshake.
    assign start     = ((state == IDLE) && finish_i) || (handshake && pend_valid);
    assign start_q   = (state == IDLE) ? quotient_i : pend_q;
    assign start_err = (start_q == ERR_CODE);

`ifdef DIV_RESULT_PENDING_EN
    logic slot_free;
    logic pend_store;

    assign slot_free  = !pend_valid || handshake;
    assign pend_store = finish_i && (state != IDLE) && slot_free;
    assign drop       = finish_i && (state != IDLE) && !slot_free;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pend_valid <= 1'b0;
            pend_q     <= '0;
        end else if (pend_store) begin
            pend_valid <= 1'b1;
            pend_q     <= quotient_i;
        end else if (handshake) begin
            pend_valid <= 1'b0;
        end
    end
`else
    assign pend_valid = 1'b0;
    assign pend_q     = '0;
    assign drop       = finish_i && (state != IDLE);
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (finish_i) state_next = start_err ? DONE : SHIFT;
            SHIFT:   if (count == LAST) state_next = DONE;
            DONE:    if (ready_i) state_next = pend_valid ? (start_err ? DONE : SHIFT) : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_o    = (state != IDLE);
        valid_o   = (state == DONE);
        bcd_o     = bcd_q;
        err_o     = err_q;
        overrun_o = overrun_q;
    end

    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sreg      <= '0;
            acc       <= '0;
            count     <= '0;
            bcd_q     <= '0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (start) begin
                count <= '0;
                if (start_err) begin
                    err_q <= 1'b1;
                    bcd_q <= '0;
                end else begin
                    sreg <= start_q;
                    acc  <= '0;
                end
            end else if (state == SHIFT) begin
                if (count == LAST) begin
                    bcd_q <= acc;
                    err_q <= 1'b0;
                end else begin
                    acc   <= {acc_adj[BW-2:0], sreg[QW-1]};
                    sreg  <= {sreg[QW-2:0], 1'b0};
                    count <= count + 1'b1;
                end
            end
            if (drop) overrun_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_div_result_bcd.sv
// Self-checking bench for div_result_bcd: directed cases plus random traffic against a transaction-level model.
module tb_div_result_bcd;
    localparam int QW     = 9;
    localparam int DIGITS = 3;

    logic        clk        = 1'b0;
    logic        reset_i    = 1'b1;
    logic        finish_i   = 1'b0;
    logic        ready_i    = 1'b0;
    logic [8:0]  quotient_i = '0;
    logic        valid_o;
    logic [11:0] bcd_o;
    logic        err_o;
    logic        busy_o;
    logic        overrun_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_result_bcd #(.QW(QW), .DIGITS(DIGITS)) dut (
        .clk_i(clk), .reset_i(reset_i), .finish_i(finish_i), .quotient_i(quotient_i),
        .ready_i(ready_i), .valid_o(valid_o), .bcd_o(bcd_o), .err_o(err_o),
        .busy_o(busy_o), .overrun_o(overrun_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input logic [8:0] q);
        int v;
        v = int'(q);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Model: a result appears QW+1 edges after capture; error code is presented immediately.
    bit          m_busy  = 0;
    bit          m_valid = 0;
    bit          m_err   = 0;
    bit          m_ovr   = 0;
    bit          m_pend  = 0;
    bit          m_cons  = 0;
    bit          m_was_busy = 0;
    int          m_timer = 0;
    logic [11:0] m_bcd   = '0;
    logic [8:0]  m_cq    = '0;
    logic [8:0]  m_pq    = '0;

    task automatic m_start(input logic [8:0] q);
        m_busy = 1;
        if (q == 9'h1FF) begin
            m_valid = 1;
            m_err   = 1;
            m_bcd   = '0;
        end else begin
            m_valid = 0;
            m_timer = QW + 1;
            m_cq    = q;
        end
    endtask

    always @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            m_busy = 0; m_valid = 0; m_err = 0; m_ovr = 0; m_pend = 0;
            m_timer = 0; m_bcd = '0; m_cq = '0; m_pq = '0;
        end else begin
            m_was_busy = m_busy;
            m_cons     = m_valid && ready_i;
            if (m_cons) begin
                if (m_pend) begin
                    m_pend = 0;
                    m_start(m_pq);
                end else begin
                    m_busy  = 0;
                    m_valid = 0;
                end
            end else if (m_busy && !m_valid) begin
                m_timer--;
                if (m_timer == 0) begin
                    m_valid = 1;
                    m_err   = 0;
                    m_bcd   = to_bcd(m_cq);
                end
            end
            if (finish_i) begin
                if (!m_was_busy) m_start(quotient_i);
`ifdef DIV_RESULT_PENDING_EN
                else if (!m_pend) begin
                    m_pend = 1;
                    m_pq   = quotient_i;
                end else m_ovr = 1;
`else
                else m_ovr = 1;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_i) begin
            chk("model_valid", valid_o, m_valid);
            chk("model_busy", busy_o, m_busy);
            chk("model_overrun", overrun_o, m_ovr);
            if (m_valid) begin
                chk("model_bcd", bcd_o, m_bcd);
                chk("model_err", err_o, m_err);
            end
        end
    end

    task automatic cyc(input logic f, input logic [8:0] q, input logic r);
        finish_i   = f;
        quotient_i = q;
        ready_i    = r;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input logic r, output int n);
        n = 0;
        while (!valid_o && n < 40) begin
            cyc(1'b0, '0, r);
            n++;
        end
        chk("wait_valid", valid_o, 1'b1);
    endtask

    task automatic run_one(input logic [8:0] q, input logic [11:0] exp);
        int n;
        cyc(1'b1, q, 1'b1);
        wait_valid(1'b1, n);
        chk("run_bcd", bcd_o, exp);
        chk("run_err", err_o, 1'b0);
        cyc(1'b0, '0, 1'b1);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        #1;
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_overrun", overrun_o, 1'b0);
        chk("rst_bcd", bcd_o, 12'h000);
        chk("rst_err", err_o, 1'b0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
    endtask

    initial begin
        int n;
        logic f, r;
        logic [8:0] q;

        do_reset();

        // 255: valid exactly 10 edges after capture, for one cycle
        cyc(1'b1, 9'd255, 1'b1);
        wait_valid(1'b1, n);
        chk("lat_255", n, 10);
        chk("bcd_255", bcd_o, 12'h255);
        chk("err_255", err_o, 1'b0);
        cyc(1'b0, '0, 1'b1);
        chk("valid_one_cycle", valid_o, 1'b0);

        // divide-by-zero code, held while ready is low
        cyc(1'b1, 9'h1FF, 1'b0);
        chk("dz_valid", valid_o, 1'b1);
        chk("dz_err", err_o, 1'b1);
        chk("dz_bcd", bcd_o, 12'h000);
        repeat (5) begin
            cyc(1'b0, '0, 1'b0);
            chk("dz_hold_valid", valid_o, 1'b1);
            chk("dz_hold_err", err_o, 1'b1);
            chk("dz_hold_bcd", bcd_o, 12'h000);
        end
        cyc(1'b0, '0, 1'b1);
        chk("dz_release", valid_o, 1'b0);

        run_one(9'd0, 12'h000);
        run_one(9'd7, 12'h007);
        run_one(9'd510, 12'h510);
        run_one(9'd99, 12'h099);

        // two pulses while DONE is stalled
        cyc(1'b1, 9'd5, 1'b0);
        wait_valid(1'b0, n);
        chk("stall_bcd", bcd_o, 12'h005);
        cyc(1'b1, 9'd42, 1'b0);
        cyc(1'b1, 9'd99, 1'b0);
        chk("ovr_set", overrun_o, 1'b1);
`ifdef DIV_RESULT_PENDING_EN
        cyc(1'b0, '0, 1'b1);
        wait_valid(1'b1, n);
        chk("pend_bcd_042", bcd_o, 12'h042);
        cyc(1'b0, '0, 1'b1);
        repeat (15) begin
            cyc(1'b0, '0, 1'b1);
            chk("no_099", valid_o, 1'b0);
        end
`else
        cyc(1'b0, '0, 1'b1);
        chk("drop_valid", valid_o, 1'b0);
        repeat (12) begin
            cyc(1'b0, '0, 1'b1);
            chk("drop_idle", busy_o, 1'b0);
        end
`endif
        chk("ovr_sticky", overrun_o, 1'b1);
        do_reset();

`ifdef DIV_RESULT_PENDING_EN
        // pending consumed and refilled on the same handshake edge
        cyc(1'b1, 9'd1, 1'b0);
        wait_valid(1'b0, n);
        cyc(1'b1, 9'd13, 1'b0);
        cyc(1'b1, 9'd200, 1'b1);
        wait_valid(1'b1, n);
        chk("pend_013", bcd_o, 12'h013);
        cyc(1'b0, '0, 1'b1);
        wait_valid(1'b1, n);
        chk("pend_200", bcd_o, 12'h200);
        chk("pend_no_ovr", overrun_o, 1'b0);
        cyc(1'b0, '0, 1'b1);
`endif

        // asynchronous reset in the middle of a conversion
        cyc(1'b1, 9'd300, 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b0);
        #3;
        chk("pre_rst_busy", busy_o, 1'b1);
        do_reset();
        run_one(9'd300, 12'h300);

        // random traffic, checked cycle by cycle by the model
        repeat (3000) begin
            f = ($urandom % 4) == 0;
            q = (($urandom % 8) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
            r = ($urandom % 3) != 0;
            cyc(f, q, r);
        end
        repeat (40) cyc(1'b0, '0, 1'b1);
        chk("drain_idle", busy_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
